// File: rtl/uart_pkg.sv
`default_nettype none
//==============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the memory-mapped UART transmitter:
//            FSM state encoding, status word bit positions, control bit
//            position and a helper that packs the status word.
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package uart_pkg;

    // Transmit FSM state encoding
    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

    // Status word (RD) bit positions
    localparam int UART_ST_FULL    = 0;
    localparam int UART_ST_BUSY    = 1;
    localparam int UART_ST_EMPTY   = 2;
    localparam int UART_ST_OVF     = 3;
    localparam int UART_ST_LVL_LSB = 4;
    localparam int UART_LVL_W      = 4;

    // WD bit that marks a control write instead of a data write
    localparam int UART_CTRL_BIT = 31;

    function automatic logic [31:0] uart_pack_status(
        input logic                  full,
        input logic                  busy,
        input logic                  empty,
        input logic                  ovf,
        input logic [UART_LVL_W-1:0] level
    );
        logic [31:0] word;
        word                                          = '0;
        word[UART_ST_FULL]                            = full;
        word[UART_ST_BUSY]                            = busy;
        word[UART_ST_EMPTY]                           = empty;
        word[UART_ST_OVF]                             = ovf;
        word[UART_ST_LVL_LSB +: UART_LVL_W]           = level;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
//==============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte buffer between the bus write port and the serializer.
//            Build option UART_TX_FIFO_EN:
//              defined   -> DEPTH-entry circular buffer (DEPTH power of 2, 2..8)
//              undefined -> single holding register (DEPTH ignored)
// Ports    : clk, rst_n      - clock, synchronous active-low reset
//            i_push/i_wdata  - enqueue request and byte
//            i_pop           - dequeue head (only asserted when non-empty)
//            o_rdata         - head byte
//            o_full/o_empty  - occupancy flags
//            o_level         - number of buffered entries
// Revision : 1.0 - initial release
//==============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [7:0]            i_wdata,
    input  logic                  i_pop,
    output logic [7:0]            o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [UART_LVL_W-1:0] o_level
);

`ifdef UART_TX_FIFO_EN

    generate
        if ((DEPTH < 2) || (DEPTH > 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of two in 2..8");
        end
    endgenerate

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [7:0]            r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [UART_LVL_W-1:0] r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_full    = (r_count == UART_LVL_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A pop on the same edge frees the slot, so a write while full still lands
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + UART_LVL_W'(1);
                2'b01:   r_count <= r_count - UART_LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_count;

`else

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be at least 1");
        end
    endgenerate

    logic [7:0] r_hold;
    logic       r_valid;
    logic       w_do_push;

    assign w_do_push = i_push && (!r_valid || i_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_hold  <= i_wdata;
                r_valid <= 1'b1;
            end else if (i_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rdata = r_hold;
    assign o_full  = r_valid;
    assign o_empty = !r_valid;
    assign o_level = {{(UART_LVL_W-1){1'b0}}, r_valid};

`endif

endmodule
`default_nettype wire

// File: rtl/peripheral_uart_tx.sv
`default_nettype none
//==============================================================================
// Module   : peripheral_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter. Bus writes either enqueue a
//            byte (WD[31]=0) or clear the sticky overflow flag (WD[31]=1).
//            Buffer implementation selected by UART_TX_FIFO_EN (see
//            uart_tx_fifo).
// Ports    : clk   - system clock
//            rst_n - synchronous active-low reset
//            WD    - write data
//            WE    - address-qualified write strobe
//            RD    - status {level[7:4], overflow, empty, busy, full}
//            tx    - serial output, idle high
// Revision : 1.0 - initial release
//==============================================================================
module peripheral_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        tx
);

    localparam int c_DIVISOR = CLK_FREQ / BAUD;
    localparam int c_CNT_W   = (c_DIVISOR < 2) ? 1 : $clog2(c_DIVISOR);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_DIVISOR - 1);

    generate
        if (c_DIVISOR < 2) begin : g_bad_divisor
            $error("peripheral_uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_bit_idx_nxt;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_ovf;

    logic                  w_push;
    logic                  w_ctrl_wr;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_baud_done;
    logic                  w_busy;
    logic [7:0]            w_fifo_rdata;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [UART_LVL_W-1:0] w_fifo_level;
    logic                  w_unused_wd;

    assign w_ctrl_wr   = WE &&  WD[UART_CTRL_BIT];
    assign w_push      = WE && !WD[UART_CTRL_BIT];
    assign w_unused_wd = ^WD[30:8];

    uart_tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (WD[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign w_baud_done = (r_cnt == c_CNT_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + c_CNT_W'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        w_tx_nxt      = 1'b1;

        case (r_state)
            UART_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_rdata;
                    w_state_nxt = UART_START;
                end
            end
            UART_START: begin
                if (w_baud_done) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = UART_DATA;
                end
            end
            UART_DATA: begin
                if (w_baud_done) begin
                    w_cnt_nxt   = '0;
                    // The line always shows shift[0]; shifting right exposes the next bit
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = UART_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            UART_STOP: begin
                if (w_baud_done) begin
                    w_cnt_nxt = '0;
                    // Chain straight into the next start bit when data is waiting
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_rdata;
                        w_state_nxt = UART_START;
                    end else begin
                        w_state_nxt = UART_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = UART_IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes on the same
        // edge as the state it belongs to
        case (w_state_nxt)
            UART_START: w_tx_nxt = 1'b0;
            UART_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:    w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= UART_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // A write to a full buffer is only dropped when no pop frees a slot
    assign w_drop = w_push && w_fifo_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_busy = (r_state != UART_IDLE) || !w_fifo_empty;
    assign RD     = uart_pack_status(w_fifo_full, w_busy, w_fifo_empty, r_ovf, w_fifo_level);
    assign tx     = r_tx;

endmodule
`default_nettype wire

// File: doc/peripheral_uart_tx.md
# peripheral_uart_tx

Memory-mapped UART transmitter peripheral for the microcontroller's peripheral bus, occupying word address 16 in the peripheral decoder alongside digital in/out, timer0 and the 7-segment display. The core writes bytes through the shared `A`/`WD`/`WE` bus. Bytes are buffered and serialized as 8N1 frames on `tx`. Status is returned combinationally on `RD` for the decoder's read multiplexer.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bits per second. Bit period `DIVISOR = CLK_FREQ / BAUD`, truncated. Elaboration error if `DIVISOR < 2`.
- `FIFO_DEPTH`, default 4: buffer entries, power of two. Only used when the FIFO is compiled in.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `WD`, input, 32: write data.
- `WE`, input, 1: write strobe. The decoder has already qualified it with the address.
- `RD`, output, 32: status word, combinational from registers.
- `tx`, output, 1: serial line, idle high.

## Operation
**Write decode** (sampled on the edge where `WE`=1):
- `WD[31]`=1: control write. Clears the sticky `overflow` flag. Nothing is enqueued.
- `WD[31]`=0: data write. `WD[7:0]` is enqueued. If the buffer is full, the byte is dropped and `overflow` is set.

**RD layout:**
- `[0]` full
- `[1]` busy: FSM not IDLE, or buffer non-empty
- `[2]` empty
- `[3]` overflow
- `[7:4]` level: number of buffered entries
- all other bits 0

**FSM states:** IDLE, START, DATA, STOP.
- IDLE: `tx`=1. If the buffer is non-empty, pop the head into the shift register, go to START.
- START: `tx`=0 for `DIVISOR` cycles, then go to DATA with bit index 0.
- DATA: `tx` = shift bit, LSB first. Each bit lasts `DIVISOR` cycles. After bit 7, go to STOP.
- STOP: `tx`=1 for `DIVISOR` cycles. Then, if the buffer is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.

**Baud counter:** counts 0..`DIVISOR`-1, is cleared on every state or bit change, and is held at 0 in IDLE.

**Boundary conditions:**
- Push and pop on the same edge while full: the pop frees a slot, so the write is accepted and there is no overflow.
- Push and pop on the same edge while empty: not possible, because a pop requires non-empty at the prior edge.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- Level saturates at `FIFO_DEPTH` and never exceeds it.

## Timing
- **Reset values:** `tx`=1, state IDLE, buffer empty, `overflow`=0, so `RD`=0x0000_0004.
- **Reset mid-frame:** the frame is aborted. `tx`=1 after the reset edge and buffered data is discarded.
- **Write-to-line latency:** a data write sampled at edge k into an idle block is buffered after edge k and popped at edge k+1. `tx` goes low after edge k+1.
- **Frame length:** exactly 10×`DIVISOR` cycles. Back-to-back frames are contiguous.
- **Status visibility:** `RD` reflects the new state in the cycle after the updating edge. There is no read side-effect.

## Configuration
`UART_TX_FIFO_EN`:
- **Defined:** a `FIFO_DEPTH`-entry circular buffer.
- **Undefined:** a single holding register. Depth is 1, full = holding valid, empty = !full, level ∈ {0,1}. `FIFO_DEPTH` is ignored.
- FSM, `RD` layout and overflow semantics are identical in both builds.

## Structure
- **Package `uart_pkg`:**
  - state enum (IDLE, START, DATA, STOP)
  - `RD` bit-position constants (`UART_ST_FULL`, `UART_ST_BUSY`, `UART_ST_EMPTY`, `UART_ST_OVF`, `UART_ST_LVL_LSB`)
  - `UART_CTRL_BIT` = 31
- **Sub-module `uart_tx_fifo`:** the buffer, selected by the macro. Push/pop/full/empty/level interface.
- **Top level:** FSM, baud counter and shift register live in `peripheral_uart_tx`.

## Test plan
All scenarios use `CLK_FREQ`=1_000_000 and `BAUD`=100_000, so `DIVISOR`=10.

1. **Reset:** hold `rst_n`=0 for 3 cycles → `tx`=1, `RD`=0x0000_0004.
2. **Single byte:** write 0x55 → `tx` falls one edge after the write edge. Sequence 0,1,0,1,0,1,0,1,0,1, each level exactly 10 cycles. `busy`=0 after 100 cycles.
3. **Back-to-back:** write 0xA5 then 0x3C on consecutive cycles → the second start bit begins exactly 100 cycles after the first. `tx` pattern 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1.
4. **Overflow (FIFO build):** 6 consecutive writes 0x01..0x06 → 0x01 in the shifter, 0x02..0x05 buffered, 0x06 dropped. `RD`=0x0000_004B. Control write 0x8000_0000 → `RD[3]`=0. Bytes 0x01..0x05 are transmitted in order.
5. **Full plus pop:** with the buffer full, a data write on the edge of a STOP→START pop → accepted, level stays 4, `overflow`=0.
6. **Reset mid-frame:** assert `rst_n`=0 during bit 3 of 0xFF → `tx`=1 the next cycle. After release, `RD`=0x0000_0004 and no frame resumes.
